// File: rtl/lane_deskew.sv
`default_nettype none
// ============================================================================
// Module      : lane_deskew
// Description : Two-lane byte deskew. Finds the ordered-set marker on each
//               lane, measures the lane-to-lane skew and delays the early
//               lane so both lanes leave aligned. Optional lock monitor is
//               enabled by defining DESKEW_MONITOR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_deskew #(
    parameter logic [7:0] MARKER   = 8'hF0,
    parameter int         MAX_SKEW = 7
) (
    input  logic       enc_clk,
    input  logic       rst,
    input  logic       enable_deskew,
    input  logic       data_os,
    input  logic [7:0] lane_0_rx,
    input  logic [7:0] lane_1_rx,
    output logic [7:0] lane_0_out,
    output logic [7:0] lane_1_out,
    output logic       data_os_out,
    output logic       deskew_done,
    output logic       deskew_err,
    output logic [3:0] skew_val,
    output logic       lead_lane
);

    localparam logic [3:0] c_max_skew = 4'(MAX_SKEW);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        WAIT   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_err_nxt;
    logic [3:0] w_skew_nxt;
    logic       w_lead_nxt;
    logic       w_hit0;
    logic       w_hit1;
    logic       w_lag_hit;
    logic [7:0] w_dly0;
    logic [7:0] w_dly1;
    logic [7:0] w_sel0;
    logic [7:0] w_sel1;

    // r_dlX[k] holds the lane byte from k+1 cycles ago (tap k+1)
    logic [7:0] r_dl0 [0:MAX_SKEW-1];
    logic [7:0] r_dl1 [0:MAX_SKEW-1];

    assign w_hit0    = data_os && (lane_0_rx == MARKER);
    assign w_hit1    = data_os && (lane_1_rx == MARKER);
    assign w_lag_hit = lead_lane ? w_hit0 : w_hit1;

    // Measured skew and lead lane as they will be after this edge
    always_comb begin
        w_skew_nxt = skew_val;
        w_lead_nxt = lead_lane;
        if (!enable_deskew) begin
            w_skew_nxt = 4'd0;
            w_lead_nxt = 1'b0;
        end else begin
            case (r_state)
                SEARCH: begin
                    if (w_hit0 && w_hit1) begin
                        w_skew_nxt = 4'd0;
                    end else if (w_hit0 || w_hit1) begin
                        w_lead_nxt = w_hit1;
                    end
                end
                WAIT: begin
                    if (w_lag_hit) begin
                        w_skew_nxt = r_cnt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Lead lane takes tap skew, lagging lane takes tap 0
    always_comb begin
        w_dly0 = lane_0_rx;
        w_dly1 = lane_1_rx;
        for (int k = 1; k <= MAX_SKEW; k++) begin
            if (4'(k) == w_skew_nxt) begin
                w_dly0 = r_dl0[k-1];
                w_dly1 = r_dl1[k-1];
            end
        end
        w_sel0 = w_lead_nxt ? lane_0_rx : w_dly0;
        w_sel1 = w_lead_nxt ? w_dly1    : lane_1_rx;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        if (!enable_deskew) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 4'd0;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = SEARCH;
                SEARCH: begin
                    if (w_hit0 && w_hit1) begin
                        w_state_nxt = LOCKED;
                    end else if (w_hit0 || w_hit1) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = 4'd1;
                    end
                end
                WAIT: begin
                    if (w_lag_hit) begin
                        w_state_nxt = LOCKED;
                    end else if (r_cnt == c_max_skew) begin
                        w_state_nxt = SEARCH;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                LOCKED: begin
`ifdef DESKEW_MONITOR_EN
                    if (data_os && ((w_sel0 == MARKER) ^ (w_sel1 == MARKER))) begin
                        w_state_nxt = SEARCH;
                        w_err_nxt   = 1'b1;
                    end
`endif
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            skew_val    <= 4'd0;
            lead_lane   <= 1'b0;
            deskew_err  <= 1'b0;
            deskew_done <= 1'b0;
            lane_0_out  <= 8'd0;
            lane_1_out  <= 8'd0;
            data_os_out <= 1'b0;
            for (int k = 0; k < MAX_SKEW; k++) begin
                r_dl0[k] <= 8'd0;
                r_dl1[k] <= 8'd0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            skew_val   <= w_skew_nxt;
            lead_lane  <= w_lead_nxt;
            deskew_err <= w_err_nxt;
            if (w_state_nxt == LOCKED) begin
                deskew_done <= 1'b1;
                lane_0_out  <= w_sel0;
                lane_1_out  <= w_sel1;
                data_os_out <= data_os;
            end else begin
                deskew_done <= 1'b0;
                lane_0_out  <= 8'd0;
                lane_1_out  <= 8'd0;
                data_os_out <= 1'b0;
            end
            r_dl0[0] <= lane_0_rx;
            r_dl1[0] <= lane_1_rx;
            for (int k = 1; k < MAX_SKEW; k++) begin
                r_dl0[k] <= r_dl0[k-1];
                r_dl1[k] <= r_dl1[k-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lane_deskew.sv
`default_nettype none
// ============================================================================
// Module      : tb_lane_deskew
// Description : Directed self-checking bench for lane_deskew (default
//               parameters; monitor expectations follow DESKEW_MONITOR_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_deskew;

    logic       enc_clk = 1'b0;
    logic       rst;
    logic       enable_deskew;
    logic       data_os;
    logic [7:0] lane_0_rx;
    logic [7:0] lane_1_rx;
    logic [7:0] lane_0_out;
    logic [7:0] lane_1_out;
    logic       data_os_out;
    logic       deskew_done;
    logic       deskew_err;
    logic [3:0] skew_val;
    logic       lead_lane;

    int passes = 0;
    int total  = 0;

    lane_deskew dut (
        .enc_clk       (enc_clk),
        .rst           (rst),
        .enable_deskew (enable_deskew),
        .data_os       (data_os),
        .lane_0_rx     (lane_0_rx),
        .lane_1_rx     (lane_1_rx),
        .lane_0_out    (lane_0_out),
        .lane_1_out    (lane_1_out),
        .data_os_out   (data_os_out),
        .deskew_done   (deskew_done),
        .deskew_err    (deskew_err),
        .skew_val      (skew_val),
        .lead_lane     (lead_lane)
    );

    always #5 enc_clk = ~enc_clk;

    // Observed bundle: {out0, out1, data_os_out, done, err, skew, lead}
    function automatic logic [23:0] obs();
        return {lane_0_out, lane_1_out, data_os_out, deskew_done, deskew_err, skew_val, lead_lane};
    endfunction

    function automatic logic [23:0] ex(input logic [7:0] o0, input logic [7:0] o1, input logic dos,
                                       input logic done, input logic err, input logic [3:0] skew,
                                       input logic lead);
        return {o0, o1, dos, done, err, skew, lead};
    endfunction

    task automatic chk(input string tag, input logic [23:0] expv);
        logic [23:0] o;
        o = obs();
        total++;
        assert (o === expv) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, expv);
    endtask

    task automatic cyc(input logic dos, input logic [7:0] a, input logic [7:0] b);
        data_os   = dos;
        lane_0_rx = a;
        lane_1_rx = b;
        @(posedge enc_clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; enable_deskew = 1'b0; data_os = 1'b0; lane_0_rx = 8'h00; lane_1_rx = 8'h00;
        cyc(0, 8'h00, 8'h00);
        cyc(1, 8'hF0, 8'hF0);
        chk("reset_state", 24'h0);

        rst = 1'b1; enable_deskew = 1'b1;
        cyc(0, 8'h00, 8'h00);
        chk("idle_to_search", 24'h0);

        // zero skew
        cyc(1, 8'hF0, 8'hF0);
        chk("zero_lock", ex(8'hF0, 8'hF0, 1, 1, 0, 4'd0, 0));
        cyc(0, 8'h11, 8'h22);
        chk("zero_data1", ex(8'h11, 8'h22, 0, 1, 0, 4'd0, 0));
        cyc(1, 8'h33, 8'h44);
        chk("zero_data2", ex(8'h33, 8'h44, 1, 1, 0, 4'd0, 0));

        // markers without data_os are ignored
        enable_deskew = 1'b0; cyc(0, 8'h00, 8'h00);
        chk("disable_idle", 24'h0);
        enable_deskew = 1'b1; cyc(0, 8'h00, 8'h00);
        cyc(0, 8'hF0, 8'hF0);
        chk("no_os_1", 24'h0);
        cyc(0, 8'hF0, 8'hF0);
        chk("no_os_2", 24'h0);

        // lane 0 leads by 3
        cyc(1, 8'hF0, 8'hB0);
        chk("lead0_wait", 24'h0);
        cyc(0, 8'hA1, 8'hB1);
        cyc(0, 8'hA2, 8'hB2);
        chk("lead0_waiting", 24'h0);
        cyc(1, 8'hA3, 8'hF0);
        chk("lead0_lock", ex(8'hF0, 8'hF0, 1, 1, 0, 4'd3, 0));
        cyc(0, 8'hA4, 8'hB4);
        chk("lead0_align1", ex(8'hA1, 8'hB4, 0, 1, 0, 4'd3, 0));
        cyc(0, 8'hA5, 8'hB5);
        chk("lead0_align2", ex(8'hA2, 8'hB5, 0, 1, 0, 4'd3, 0));

        // lane 1 leads by MAX_SKEW
        enable_deskew = 1'b0; cyc(0, 8'h00, 8'h00);
        chk("idle_clears", 24'h0);
        enable_deskew = 1'b1; cyc(0, 8'h00, 8'h00);
        cyc(1, 8'hC0, 8'hF0);
        chk("lead1_wait", ex(8'h00, 8'h00, 0, 0, 0, 4'd0, 1));
        for (int k = 1; k <= 6; k++) cyc(0, 8'h00, 8'h10 + 8'(k));
        chk("lead1_waiting", ex(8'h00, 8'h00, 0, 0, 0, 4'd0, 1));
        cyc(1, 8'hF0, 8'h17);
        chk("lead1_lock7", ex(8'hF0, 8'hF0, 1, 1, 0, 4'd7, 1));
        cyc(0, 8'hD8, 8'h18);
        chk("lead1_align", ex(8'hD8, 8'h11, 0, 1, 0, 4'd7, 1));

        // lag of 8 overflows
        enable_deskew = 1'b0; cyc(0, 8'h00, 8'h00);
        enable_deskew = 1'b1; cyc(0, 8'h00, 8'h00);
        cyc(1, 8'h00, 8'hF0);
        for (int k = 1; k <= 6; k++) cyc(0, 8'h00, 8'h00);
        chk("ovf_before", ex(8'h00, 8'h00, 0, 0, 0, 4'd0, 1));
        cyc(0, 8'h00, 8'h00);
        chk("ovf_err", ex(8'h00, 8'h00, 0, 0, 1, 4'd0, 1));
        cyc(1, 8'hF0, 8'h00);
        chk("ovf_research", 24'h0);

        // enable dropped in WAIT, with a lagging marker present
        cyc(0, 8'h00, 8'h00);
        enable_deskew = 1'b0;
        cyc(1, 8'h00, 8'hF0);
        chk("wait_disable", 24'h0);
        enable_deskew = 1'b1; cyc(0, 8'h00, 8'h00);

        // lock at skew 2, lane 0 leading, then reset pulse
        cyc(1, 8'hF0, 8'h70);
        cyc(0, 8'h61, 8'h71);
        cyc(1, 8'h62, 8'hF0);
        chk("skew2_lock", ex(8'hF0, 8'hF0, 1, 1, 0, 4'd2, 0));
        rst = 1'b0; #1;
        chk("async_reset", 24'h0);
        cyc(1, 8'hF0, 8'hF0);
        chk("held_reset", 24'h0);
        rst = 1'b1;
        cyc(0, 8'h00, 8'h00);
        cyc(1, 8'hF0, 8'hF0);
        chk("relock", ex(8'hF0, 8'hF0, 1, 1, 0, 4'd0, 0));

        // locked at skew 2, then lane 1 marker one cycle late
        enable_deskew = 1'b0; cyc(0, 8'h00, 8'h00);
        enable_deskew = 1'b1; cyc(0, 8'h00, 8'h00);
        cyc(1, 8'hF0, 8'h70);
        cyc(0, 8'h61, 8'h71);
        cyc(1, 8'h62, 8'hF0);
        chk("mon_lock", ex(8'hF0, 8'hF0, 1, 1, 0, 4'd2, 0));
        cyc(1, 8'hF0, 8'h81);
        chk("mon_ok1", ex(8'h61, 8'h81, 1, 1, 0, 4'd2, 0));
        cyc(0, 8'h91, 8'h82);
        chk("mon_ok2", ex(8'h62, 8'h82, 0, 1, 0, 4'd2, 0));
        cyc(1, 8'h92, 8'h83);
`ifdef DESKEW_MONITOR_EN
        chk("mon_mismatch", ex(8'h00, 8'h00, 0, 0, 1, 4'd2, 0));
        cyc(1, 8'h93, 8'hF0);
        chk("mon_research", ex(8'h00, 8'h00, 0, 0, 0, 4'd2, 1));
`else
        chk("nomon_stay1", ex(8'hF0, 8'h83, 1, 1, 0, 4'd2, 0));
        cyc(1, 8'h93, 8'hF0);
        chk("nomon_stay2", ex(8'h91, 8'hF0, 1, 1, 0, 4'd2, 0));
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
`default_nettype wire
